// File: rtl/window_mean_restore_pkg.sv
// Shared definitions (package astro_pkg) for the window mean-removal / restore path.
// Window geometry, pixel types and the restore FSM state type.
package astro_pkg;

    localparam int unsigned WIN_W   = 16;
    localparam int unsigned WIN_H   = 16;
    localparam int unsigned WIN_PIX = WIN_W * WIN_H;

    typedef logic [7:0]        pix_t;
    typedef logic signed [8:0] zpix_t;

    typedef enum logic {
        IDLE,
        STREAM
    } restore_state_t;

    // sum spans -256..510, so bit 9 flags negative and bit 8 flags overflow
    function automatic pix_t clamp_u8(input logic signed [9:0] sum);
        pix_t res;
        if (sum[9])
            res = '0;
        else if (sum[8])
            res = '1;
        else
            res = sum[7:0];
        return res;
    endfunction

endpackage

// File: rtl/window_mean_restore_if.sv
// Stream interface for window_mean_restore: average, pixel-in and pixel-out handshakes.
// master drives the inputs of the block, slave is the block itself.
interface window_mean_restore_if;
    import astro_pkg::*;

    logic  avg_valid;
    pix_t  avg_in;
    logic  avg_ready;
    logic  in_valid;
    zpix_t in_data;
    logic  in_ready;
    logic  out_valid;
    pix_t  out_data;
    logic  out_last;
    logic  out_ready;

    modport master (
        output avg_valid, avg_in, in_valid, in_data, out_ready,
        input  avg_ready, in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  avg_valid, avg_in, in_valid, in_data, out_ready,
        output avg_ready, in_ready, out_valid, out_data, out_last
    );

endinterface

// File: rtl/window_mean_restore_sat_add.sv
// sat_add_u8: signed 9-bit + unsigned 8-bit, clamped to unsigned 8-bit with a saturation flag.
// Purely combinational; shared with the other reconstruction paths.
module sat_add_u8
    import astro_pkg::*;
(
    input  zpix_t zpix,
    input  pix_t  avg,
    output pix_t  res,
    output logic  sat
);

    logic signed [9:0] sum;

    always_comb begin
        sum = $signed({zpix[8], zpix}) + $signed({2'b00, avg});
        sat = sum[9] | sum[8];
        res = clamp_u8(sum);
    end

endmodule

// File: rtl/window_mean_restore.sv
// window_mean_restore: adds the window average back onto mean-subtracted pixels, clamps to u8.
// Optional saturated-pixel counter enabled by `define WINDOW_MEAN_RESTORE_SAT_CNT_EN.
module window_mean_restore
    import astro_pkg::*;
#(
    parameter  int unsigned WIN_W   = astro_pkg::WIN_W,
    parameter  int unsigned WIN_H   = astro_pkg::WIN_H,
    localparam int unsigned WIN_PIX = WIN_W * WIN_H,
    localparam int unsigned CNT_W   = $clog2(WIN_PIX)
) (
    input  logic                  clk,
    input  logic                  rst,
    window_mean_restore_if.slave  bus,
    output logic [CNT_W:0]        sat_count
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIN_PIX - 1);

    restore_state_t   state;
    restore_state_t   state_d;
    pix_t             avg_reg;
    logic [CNT_W-1:0] pix_cnt;
    logic             out_valid_q;
    pix_t             out_data_q;
    logic             out_last_q;

    logic             avg_ready_c;
    logic             in_ready_c;
    logic             avg_take;
    logic             accept;
    logic             last_acc;
    pix_t             pix_res;
    logic             pix_sat;

    assign avg_take = avg_ready_c && bus.avg_valid;
    assign accept   = in_ready_c && bus.in_valid;
    assign last_acc = accept && (pix_cnt == LAST_IDX);

    sat_add_u8 u_sat_add (
        .zpix (bus.in_data),
        .avg  (avg_reg),
        .res  (pix_res),
        .sat  (pix_sat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d     = state;
        avg_ready_c = 1'b0;
        in_ready_c  = 1'b0;
        unique case (state)
            IDLE: begin
                avg_ready_c = 1'b1;
                if (bus.avg_valid)
                    state_d = STREAM;
            end
            STREAM: begin
                // a held, unconsumed output blocks the next accept
                in_ready_c = !out_valid_q || bus.out_ready;
                if (in_ready_c && bus.in_valid && (pix_cnt == LAST_IDX))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            avg_reg     <= '0;
            pix_cnt     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            if (avg_take) begin
                avg_reg <= bus.avg_in;
                pix_cnt <= '0;
            end
            if (accept) begin
                pix_cnt     <= last_acc ? '0 : pix_cnt + 1'b1;
                out_valid_q <= 1'b1;
                out_data_q  <= pix_res;
                out_last_q  <= last_acc;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

`ifdef WINDOW_MEAN_RESTORE_SAT_CNT_EN
    logic [CNT_W:0] run_sat;
    logic [CNT_W:0] run_sat_nxt;

    assign run_sat_nxt = run_sat + {{CNT_W{1'b0}}, pix_sat};

    // the completed-window count includes the final pixel of that window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_sat   <= '0;
            sat_count <= '0;
        end else begin
            if (avg_take)
                run_sat <= '0;
            else if (accept)
                run_sat <= run_sat_nxt;
            if (last_acc)
                sat_count <= run_sat_nxt;
        end
    end
`else
    logic sat_unused;
    assign sat_unused = pix_sat;
    assign sat_count  = '0;
`endif

    assign bus.avg_ready = avg_ready_c;
    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_window_mean_restore.sv
// Self-checking bench for window_mean_restore against a queue-based reference model.
// Build with +define+WINDOW_MEAN_RESTORE_SAT_CNT_EN to also check the saturation counter.
module tb_window_mean_restore;
    import astro_pkg::*;

    localparam int unsigned NPIX  = WIN_PIX;
    localparam int unsigned CNT_W = $clog2(NPIX);

    typedef struct {
        logic [7:0] d;
        logic       l;
        int         sat;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [CNT_W:0] sat_count;

    window_mean_restore_if bus();

    window_mean_restore #(.WIN_W(WIN_W), .WIN_H(WIN_H)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .sat_count (sat_count)
    );

    always #5 clk = ~clk;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc_now = 0;
    int         n_out = 0;
    int         n_last = 0;
    int         prev_hs = -1;
    logic       prev_last = 1'b0;
    int         gap_after_last = -1;
    logic [7:0] model_avg = '0;
    int         win_sat = 0;
    zpix_t      pix[NPIX];

    always @(posedge clk) cyc_now++;

    // output scoreboard: every handshake must match the oldest modelled pixel
    always @(negedge clk) begin : mon
        exp_t           e;
        logic [CNT_W:0] es;
        if (!rst && bus.out_valid && bus.out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL out_unexpected: got data=%0d last=%0b, required no output", bus.out_data, bus.out_last);
            end else begin
                e = exp_q.pop_front();
                if (bus.out_data !== e.d || bus.out_last !== e.l) begin
                    n_fail++;
                    $display("FAIL out_data: got data=%0d last=%0b, required data=%0d last=%0b",
                             bus.out_data, bus.out_last, e.d, e.l);
                end
                if (e.l) begin
`ifdef WINDOW_MEAN_RESTORE_SAT_CNT_EN
                    es = (CNT_W+1)'(e.sat);
`else
                    es = '0;
`endif
                    n_checks++;
                    if (sat_count !== es) begin
                        n_fail++;
                        $display("FAIL sat_count: got %0d, required %0d", sat_count, es);
                    end
                end
            end
            n_out++;
            if (bus.out_last) n_last++;
            if (prev_last) gap_after_last = cyc_now - prev_hs;
            prev_hs   = cyc_now;
            prev_last = bus.out_last;
        end
    end

    // reference model: plain integer add and clamp
    function automatic void model_accept(input int idx);
        exp_t e;
        int   s;
        s     = int'(model_avg) + int'(pix[idx]);
        e.d   = (s < 0) ? 8'd0 : (s > 255) ? 8'd255 : 8'(s);
        if (s < 0 || s > 255) win_sat++;
        e.l   = (idx == NPIX - 1);
        e.sat = win_sat;
        exp_q.push_back(e);
    endfunction

    task automatic offer_avg(input logic [7:0] a);
        int t   = 0;
        bit got = 0;
        bus.avg_valid = 1'b1;
        bus.avg_in    = a;
        while (!got && t < 50) begin
            @(negedge clk);
            got = bus.avg_ready;
            @(posedge clk); #1;
            t++;
        end
        bus.avg_valid = 1'b0;
        if (got) begin
            model_avg = a;
            win_sat   = 0;
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL avg_timeout: got avg_ready=0 for %0d cycles, required 1", t);
        end
    endtask

    task automatic stream_pixels(input int n, input int stall_lo, input int stall_hi,
                                 input int pulse_at, input bit rand_valid,
                                 output int first_acc, output int first_out);
        int         idx  = 0;
        int         cyc  = 0;
        bit         held = 0;
        logic [7:0] hd   = '0;
        logic       hl   = 1'b0;
        first_acc = -1;
        first_out = -1;
        while (idx < n && cyc < n * 8 + 100) begin
            bus.in_valid  = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.in_data   = pix[idx];
            bus.out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
            bus.avg_valid = (cyc == pulse_at);
            bus.avg_in    = 8'd50;
            @(negedge clk);
            n_checks++;
            if (bus.avg_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL avg_ready_stream: got %b at pixel %0d, required 0", bus.avg_ready, idx);
            end
            if (bus.out_valid && !bus.out_ready) begin
                n_checks++;
                if (bus.in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL in_ready_stall: got %b, required 0", bus.in_ready);
                end
                if (held) begin
                    n_checks++;
                    if (bus.out_data !== hd || bus.out_last !== hl) begin
                        n_fail++;
                        $display("FAIL stall_hold: got data=%0d last=%0b, required data=%0d last=%0b",
                                 bus.out_data, bus.out_last, hd, hl);
                    end
                end
                held = 1;
                hd   = bus.out_data;
                hl   = bus.out_last;
            end else begin
                held = 0;
            end
            if (first_out < 0 && bus.out_valid) first_out = cyc;
            if (bus.in_valid && bus.in_ready) begin
                if (idx == 0) first_acc = cyc;
                model_accept(idx);
                idx++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.avg_valid = 1'b0;
        bus.out_ready = 1'b1;
        n_checks++;
        if (idx != n) begin
            n_fail++;
            $display("FAIL stream_timeout: got %0d accepts, required %0d", idx, n);
        end
        if (n == NPIX) begin
            n_checks++;
            if (bus.avg_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL avg_ready_reassert: got %b after last accept, required 1", bus.avg_ready);
            end
        end
    endtask

    task automatic drain();
        int t = 0;
        bus.out_ready = 1'b1;
        while (exp_q.size() != 0 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending outputs, required 0", exp_q.size());
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < int'(NPIX); i++) pix[i] = zpix_t'($urandom_range(0, 511));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks += 6;
        if (bus.avg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_avg_ready: got %b, required 1", bus.avg_ready); end
        if (bus.in_ready !== 1'b0)  begin n_fail++; $display("FAIL reset_in_ready: got %b, required 0", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid); end
        if (bus.out_data !== 8'd0)  begin n_fail++; $display("FAIL reset_out_data: got %0d, required 0", bus.out_data); end
        if (bus.out_last !== 1'b0)  begin n_fail++; $display("FAIL reset_out_last: got %b, required 0", bus.out_last); end
        if (sat_count !== '0)       begin n_fail++; $display("FAIL reset_sat_count: got %0d, required 0", sat_count); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int fa, fo, o0, l0;
        for (int i = 0; i < int'(NPIX); i++) pix[i] = 9'sd5;
        offer_avg(8'd100);
        o0 = n_out;
        l0 = n_last;
        stream_pixels(NPIX, -1, -1, -1, 1'b0, fa, fo);
        drain();
        n_checks += 3;
        if (fo != fa + 1) begin n_fail++; $display("FAIL basic_latency: got first out at %0d, required %0d", fo, fa + 1); end
        if (n_out - o0 != int'(NPIX)) begin n_fail++; $display("FAIL basic_count: got %0d outputs, required %0d", n_out - o0, NPIX); end
        if (n_last - l0 != 1) begin n_fail++; $display("FAIL basic_last: got %0d last flags, required 1", n_last - l0); end
    endtask

    task automatic test_saturation();
        int fa, fo;
        fill_random();
        pix[0] = 9'sd100;
        pix[1] = -9'sd50;
        pix[2] = -9'sd256;
        offer_avg(8'd200);
        stream_pixels(NPIX, -1, -1, -1, 1'b0, fa, fo);
        drain();
        for (int i = 0; i < int'(NPIX); i++) pix[i] = -9'sd20;
        offer_avg(8'd10);
        stream_pixels(NPIX, -1, -1, -1, 1'b0, fa, fo);
        drain();
    endtask

    task automatic test_backpressure();
        int fa, fo, o0;
        fill_random();
        offer_avg(8'($urandom_range(0, 255)));
        o0 = n_out;
        stream_pixels(NPIX, 3, 7, -1, 1'b0, fa, fo);
        drain();
        n_checks++;
        if (n_out - o0 != int'(NPIX)) begin n_fail++; $display("FAIL bp_count: got %0d outputs, required %0d", n_out - o0, NPIX); end
    endtask

    task automatic test_protocol_guards();
        int fa, fo;
        bus.in_valid = 1'b1;
        bus.in_data  = 9'sd7;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks += 2;
            if (bus.in_ready !== 1'b0)  begin n_fail++; $display("FAIL idle_in_ready: got %b, required 0", bus.in_ready); end
            if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_out_valid: got %b, required 0", bus.out_valid); end
            @(posedge clk); #1;
        end
        fill_random();
        offer_avg(8'($urandom_range(0, 255)));
        stream_pixels(NPIX, 20, 23, 40, 1'b1, fa, fo);
        drain();
    endtask

    task automatic test_reset_mid();
        int fa, fo, o0, l0;
        fill_random();
        offer_avg(8'($urandom_range(0, 255)));
        stream_pixels(100, -1, -1, -1, 1'b0, fa, fo);
        #2 rst = 1'b1;
        #1;
        n_checks += 4;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b, required 0", bus.out_valid); end
        if (bus.avg_ready !== 1'b1) begin n_fail++; $display("FAIL rst_avg_ready: got %b, required 1", bus.avg_ready); end
        if (bus.in_ready !== 1'b0)  begin n_fail++; $display("FAIL rst_in_ready: got %b, required 0", bus.in_ready); end
        if (bus.out_last !== 1'b0)  begin n_fail++; $display("FAIL rst_out_last: got %b, required 0", bus.out_last); end
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        fill_random();
        o0 = n_out;
        l0 = n_last;
        offer_avg(8'($urandom_range(0, 255)));
        stream_pixels(NPIX, -1, -1, -1, 1'b0, fa, fo);
        drain();
        n_checks += 2;
        if (n_out - o0 != int'(NPIX)) begin n_fail++; $display("FAIL rst_window_count: got %0d outputs, required %0d", n_out - o0, NPIX); end
        if (n_last - l0 != 1) begin n_fail++; $display("FAIL rst_window_last: got %0d last flags, required 1", n_last - l0); end
    endtask

    task automatic test_back_to_back();
        int fa, fo, l0;
        l0 = n_last;
        fill_random();
        offer_avg(8'($urandom_range(0, 255)));
        stream_pixels(NPIX, -1, -1, -1, 1'b0, fa, fo);
        fill_random();
        offer_avg(8'($urandom_range(0, 255)));
        stream_pixels(NPIX, -1, -1, -1, 1'b0, fa, fo);
        drain();
        n_checks += 2;
        if (gap_after_last < 1 || gap_after_last > 2) begin
            n_fail++;
            $display("FAIL b2b_gap: got %0d cycles between windows, required 1..2", gap_after_last);
        end
        if (n_last - l0 != 2) begin n_fail++; $display("FAIL b2b_last: got %0d last flags, required 2", n_last - l0); end
    endtask

    initial begin
        bus.avg_valid = 1'b0;
        bus.avg_in    = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_basic();
        test_saturation();
        test_backpressure();
        test_protocol_guards();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
